// File: rtl/axil_adapter_pkg.sv
// Shared definitions for the AXI4-lite read width adapters: response codes,
// width-mode derivation helpers, issuer state encoding and R-path metadata record.
package axil_adapter_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned META_LANE_W = 8;

    typedef struct packed {
        logic [META_LANE_W-1:0] lane;
        logic                   last;
    } rd_meta_t;

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } rd_issue_state_t;

    function automatic bit calc_expand(input int unsigned s_strb, input int unsigned m_strb);
        return m_strb >= s_strb;
    endfunction

    function automatic int unsigned calc_segment_count(input int unsigned s_strb, input int unsigned m_strb);
        return (m_strb >= s_strb) ? (m_strb / s_strb) : (s_strb / m_strb);
    endfunction

    function automatic int unsigned calc_addr_off(input int unsigned strb);
        return $clog2(strb);
    endfunction

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/axil_adapter_rd_meta_fifo.sv
// Synchronous metadata FIFO for in-flight downstream reads; push into a full
// FIFO is accepted when a pop happens in the same cycle.
module axil_adapter_rd_meta_fifo
    import axil_adapter_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  rd_meta_t         i_push_data,
    input  logic             i_pop,
    output rd_meta_t         o_pop_data,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rd_meta_t         r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_full;
    logic             w_wr;
    logic             w_rd;
    logic [PTR_W-1:0] w_wr_next;
    logic [PTR_W-1:0] w_rd_next;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];

    assign w_rd      = i_pop && !o_empty;
    assign w_wr      = i_push && (!w_full || w_rd);
    assign w_wr_next = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
    assign w_rd_next = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= w_wr_next;
            if (w_rd) r_rd_ptr <= w_rd_next;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/axil_adapter_rd_pipe.sv
// AXI4-lite read width adapter with up to MAX_OUTSTANDING pipelined downstream reads.
// Define AXIL_ADAPTER_RD_ERR_ZERO_EN to zero the data of non-OKAY downstream beats.
module axil_adapter_rd_pipe
    import axil_adapter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned S_DATA_WIDTH    = 32,
    parameter int unsigned S_STRB_WIDTH    = S_DATA_WIDTH / 8,
    parameter int unsigned M_DATA_WIDTH    = 32,
    parameter int unsigned M_STRB_WIDTH    = M_DATA_WIDTH / 8,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [ADDR_WIDTH-1:0]              s_axil_araddr,
    input  logic [2:0]                         s_axil_arprot,
    input  logic                               s_axil_arvalid,
    output logic                               s_axil_arready,
    output logic [S_DATA_WIDTH-1:0]            s_axil_rdata,
    output logic [1:0]                         s_axil_rresp,
    output logic                               s_axil_rvalid,
    input  logic                               s_axil_rready,
    output logic [ADDR_WIDTH-1:0]              m_axil_araddr,
    output logic [2:0]                         m_axil_arprot,
    output logic                               m_axil_arvalid,
    input  logic                               m_axil_arready,
    input  logic [M_DATA_WIDTH-1:0]            m_axil_rdata,
    input  logic [1:0]                         m_axil_rresp,
    input  logic                               m_axil_rvalid,
    output logic                               m_axil_rready,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_count
);

    localparam bit          EXPAND    = calc_expand(S_STRB_WIDTH, M_STRB_WIDTH);
    localparam int unsigned SEG_COUNT = calc_segment_count(S_STRB_WIDTH, M_STRB_WIDTH);
    localparam int unsigned S_OFF     = calc_addr_off(S_STRB_WIDTH);
    localparam int unsigned SEG_W     = (SEG_COUNT > 1) ? $clog2(SEG_COUNT) : 1;
    localparam int unsigned CNT_W     = $clog2(MAX_OUTSTANDING + 1);

    if (S_DATA_WIDTH / S_STRB_WIDTH != M_DATA_WIDTH / M_STRB_WIDTH) begin : g_err_word
        $error("axil_adapter_rd_pipe: word size differs between sides");
    end
    if (!is_pow2(S_STRB_WIDTH) || !is_pow2(M_STRB_WIDTH)) begin : g_err_pow2
        $error("axil_adapter_rd_pipe: word counts must be powers of two");
    end
    if (MAX_OUTSTANDING < 1) begin : g_err_outst
        $error("axil_adapter_rd_pipe: MAX_OUTSTANDING must be at least 1");
    end

    rd_issue_state_t           r_state;
    logic                      r_s_arready;
    logic                      r_m_arvalid;
    logic [ADDR_WIDTH-1:0]     r_m_araddr;
    logic [2:0]                r_m_arprot;
    logic [SEG_W-1:0]          r_beat;
    logic [META_LANE_W-1:0]    r_lane;
    logic                      r_s_rvalid;
    logic [1:0]                r_s_rresp;
    logic [1:0]                r_resp_acc;
    logic [S_DATA_WIDTH-1:0]   r_s_rdata;

    logic                      w_push;
    logic                      w_pop;
    logic                      w_ar_last;
    logic                      w_fifo_empty;
    logic [CNT_W-1:0]          w_cnt;
    logic [CNT_W:0]            w_cnt_next;
    logic                      w_can_issue;
    logic                      w_m_rready;
    logic [META_LANE_W-1:0]    w_s_lane;
    logic [ADDR_WIDTH-1:0]     w_s_base;
    logic [M_DATA_WIDTH-1:0]   w_beat_data;
    logic [1:0]                w_resp_cur;
    rd_meta_t                  w_meta_in;
    rd_meta_t                  w_meta_out;

    assign s_axil_arready    = r_s_arready;
    assign m_axil_arvalid    = r_m_arvalid;
    assign m_axil_araddr     = r_m_araddr;
    assign m_axil_arprot     = r_m_arprot;
    assign m_axil_rready     = w_m_rready;
    assign s_axil_rvalid     = r_s_rvalid;
    assign s_axil_rresp      = r_s_rresp;
    assign s_axil_rdata      = r_s_rdata;
    assign outstanding_count = w_cnt;

    assign w_push    = r_m_arvalid && m_axil_arready;
    assign w_ar_last = EXPAND || (r_beat == SEG_W'(SEG_COUNT - 1));
    assign w_s_lane  = META_LANE_W'((s_axil_araddr >> S_OFF) & ADDR_WIDTH'(SEG_COUNT - 1));
    assign w_s_base  = s_axil_araddr & ~ADDR_WIDTH'(S_STRB_WIDTH - 1);

    // Issue decision looks at next cycle's count so a registered arvalid never overshoots.
    assign w_cnt_next  = {1'b0, w_cnt} + {{CNT_W{1'b0}}, w_push} - {{CNT_W{1'b0}}, w_pop};
    assign w_can_issue = (w_cnt_next < (CNT_W+1)'(MAX_OUTSTANDING));

    assign w_meta_in.lane = EXPAND ? r_lane : META_LANE_W'(r_beat);
    assign w_meta_in.last = w_ar_last;

    axil_adapter_rd_meta_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_meta_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_meta_in),
        .i_pop       (w_pop),
        .o_pop_data  (w_meta_out),
        .o_empty     (w_fifo_empty),
        .o_count     (w_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_s_arready <= 1'b0;
            r_m_arvalid <= 1'b0;
            r_beat      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_s_arready <= 1'b1;
                    if (r_s_arready && s_axil_arvalid) begin
                        r_s_arready <= 1'b0;
                        r_state     <= ST_ISSUE;
                        r_m_araddr  <= EXPAND ? s_axil_araddr : w_s_base;
                        r_m_arprot  <= s_axil_arprot;
                        r_lane      <= w_s_lane;
                        r_beat      <= '0;
                        r_m_arvalid <= w_can_issue;
                    end
                end
                ST_ISSUE: begin
                    if (w_push) begin
                        if (w_ar_last) begin
                            r_state     <= ST_IDLE;
                            r_m_arvalid <= 1'b0;
                            r_s_arready <= 1'b1;
                        end else begin
                            r_beat      <= r_beat + SEG_W'(1);
                            r_m_araddr  <= r_m_araddr + ADDR_WIDTH'(M_STRB_WIDTH);
                            r_m_arvalid <= w_can_issue;
                        end
                    end else if (!r_m_arvalid) begin
                        r_m_arvalid <= w_can_issue;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_m_rready = !w_fifo_empty && (!r_s_rvalid || s_axil_rready);
    assign w_pop      = w_m_rready && m_axil_rvalid;
    assign w_resp_cur = (r_resp_acc != RESP_OKAY) ? r_resp_acc : m_axil_rresp;

`ifdef AXIL_ADAPTER_RD_ERR_ZERO_EN
    assign w_beat_data = (m_axil_rresp != RESP_OKAY) ? '0 : m_axil_rdata;
`else
    assign w_beat_data = m_axil_rdata;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_rvalid <= 1'b0;
            r_resp_acc <= RESP_OKAY;
        end else begin
            if (s_axil_rready) r_s_rvalid <= 1'b0;
            if (w_pop) begin
                if (w_meta_out.last) begin
                    r_s_rvalid <= 1'b1;
                    r_s_rresp  <= w_resp_cur;
                    r_resp_acc <= RESP_OKAY;
                end else begin
                    r_resp_acc <= w_resp_cur;
                end
            end
        end
    end

    // The response register doubles as the narrow-mode assembly buffer; it is only
    // rewritten after the previous response has been accepted upstream.
    if (EXPAND) begin : g_expand
        always_ff @(posedge clk) begin
            if (w_pop) begin
                r_s_rdata <= S_DATA_WIDTH'(w_beat_data >> (int'(w_meta_out.lane) * S_DATA_WIDTH));
            end
        end
    end else begin : g_narrow
        always_ff @(posedge clk) begin
            if (w_pop) begin
                r_s_rdata[int'(w_meta_out.lane[SEG_W-1:0]) * M_DATA_WIDTH +: M_DATA_WIDTH] <= w_beat_data;
            end
        end
    end

endmodule

// File: tb/tb_axil_adapter_rd_pipe.sv
// Directed bench for axil_adapter_rd_pipe in equal (S32/M32), expand (S32/M64)
// and narrow (S64/M32) configurations; expectations follow AXIL_ADAPTER_RD_ERR_ZERO_EN.
module tb_axil_adapter_rd_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- instance A: S32/M32 ----------------
    logic [31:0] a_s_araddr, a_s_rdata, a_m_araddr, a_m_rdata;
    logic [2:0]  a_s_arprot, a_m_arprot, a_cnt;
    logic [1:0]  a_s_rresp, a_m_rresp;
    logic a_s_arvalid, a_s_arready, a_s_rvalid, a_s_rready;
    logic a_m_arvalid, a_m_arready, a_m_rvalid, a_m_rready;

    axil_adapter_rd_pipe #(
        .ADDR_WIDTH(32), .S_DATA_WIDTH(32), .M_DATA_WIDTH(32), .MAX_OUTSTANDING(4)
    ) u_a (
        .clk(clk), .rst(rst),
        .s_axil_araddr(a_s_araddr), .s_axil_arprot(a_s_arprot), .s_axil_arvalid(a_s_arvalid),
        .s_axil_arready(a_s_arready), .s_axil_rdata(a_s_rdata), .s_axil_rresp(a_s_rresp),
        .s_axil_rvalid(a_s_rvalid), .s_axil_rready(a_s_rready),
        .m_axil_araddr(a_m_araddr), .m_axil_arprot(a_m_arprot), .m_axil_arvalid(a_m_arvalid),
        .m_axil_arready(a_m_arready), .m_axil_rdata(a_m_rdata), .m_axil_rresp(a_m_rresp),
        .m_axil_rvalid(a_m_rvalid), .m_axil_rready(a_m_rready), .outstanding_count(a_cnt)
    );

    // ---------------- instance B: S32/M64 ----------------
    logic [31:0] b_s_araddr, b_s_rdata, b_m_araddr;
    logic [63:0] b_m_rdata;
    logic [2:0]  b_s_arprot, b_m_arprot, b_cnt;
    logic [1:0]  b_s_rresp, b_m_rresp;
    logic b_s_arvalid, b_s_arready, b_s_rvalid, b_s_rready;
    logic b_m_arvalid, b_m_arready, b_m_rvalid, b_m_rready;

    axil_adapter_rd_pipe #(
        .ADDR_WIDTH(32), .S_DATA_WIDTH(32), .M_DATA_WIDTH(64), .MAX_OUTSTANDING(4)
    ) u_b (
        .clk(clk), .rst(rst),
        .s_axil_araddr(b_s_araddr), .s_axil_arprot(b_s_arprot), .s_axil_arvalid(b_s_arvalid),
        .s_axil_arready(b_s_arready), .s_axil_rdata(b_s_rdata), .s_axil_rresp(b_s_rresp),
        .s_axil_rvalid(b_s_rvalid), .s_axil_rready(b_s_rready),
        .m_axil_araddr(b_m_araddr), .m_axil_arprot(b_m_arprot), .m_axil_arvalid(b_m_arvalid),
        .m_axil_arready(b_m_arready), .m_axil_rdata(b_m_rdata), .m_axil_rresp(b_m_rresp),
        .m_axil_rvalid(b_m_rvalid), .m_axil_rready(b_m_rready), .outstanding_count(b_cnt)
    );

    // ---------------- instance C: S64/M32 ----------------
    logic [31:0] c_s_araddr, c_m_araddr, c_m_rdata;
    logic [63:0] c_s_rdata;
    logic [2:0]  c_s_arprot, c_m_arprot, c_cnt;
    logic [1:0]  c_s_rresp, c_m_rresp;
    logic c_s_arvalid, c_s_arready, c_s_rvalid, c_s_rready;
    logic c_m_arvalid, c_m_arready, c_m_rvalid, c_m_rready;

    axil_adapter_rd_pipe #(
        .ADDR_WIDTH(32), .S_DATA_WIDTH(64), .M_DATA_WIDTH(32), .MAX_OUTSTANDING(4)
    ) u_c (
        .clk(clk), .rst(rst),
        .s_axil_araddr(c_s_araddr), .s_axil_arprot(c_s_arprot), .s_axil_arvalid(c_s_arvalid),
        .s_axil_arready(c_s_arready), .s_axil_rdata(c_s_rdata), .s_axil_rresp(c_s_rresp),
        .s_axil_rvalid(c_s_rvalid), .s_axil_rready(c_s_rready),
        .m_axil_araddr(c_m_araddr), .m_axil_arprot(c_m_arprot), .m_axil_arvalid(c_m_arvalid),
        .m_axil_arready(c_m_arready), .m_axil_rdata(c_m_rdata), .m_axil_rresp(c_m_rresp),
        .m_axil_rvalid(c_m_rvalid), .m_axil_rready(c_m_rready), .outstanding_count(c_cnt)
    );

    // Handshake monitors
    logic [31:0] a_arq[$], c_arq[$];
    logic [63:0] a_rq[$], b_rq[$], c_rq[$];
    logic [1:0]  b_rsq[$], c_rsq[$];

    always @(posedge clk) begin
        if (!rst) begin
            if (a_m_arvalid && a_m_arready) a_arq.push_back(a_m_araddr);
            if (c_m_arvalid && c_m_arready) c_arq.push_back(c_m_araddr);
            if (a_s_rvalid && a_s_rready) a_rq.push_back({32'h0, a_s_rdata});
            if (b_s_rvalid && b_s_rready) begin
                b_rq.push_back({32'h0, b_s_rdata});
                b_rsq.push_back(b_s_rresp);
            end
            if (c_s_rvalid && c_s_rready) begin
                c_rq.push_back(c_s_rdata);
                c_rsq.push_back(c_s_rresp);
            end
        end
    end

    // Upstream AR drivers and downstream R responders (all waits bounded)
    task automatic a_ar(input logic [31:0] addr);
        a_s_araddr = addr; a_s_arvalid = 1'b1;
        for (int n = 0; n < 40 && !a_s_arready; n++) step();
        check("a_arready", a_s_arready, 1);
        step(); a_s_arvalid = 1'b0;
    endtask

    task automatic b_ar(input logic [31:0] addr);
        b_s_araddr = addr; b_s_arvalid = 1'b1;
        for (int n = 0; n < 40 && !b_s_arready; n++) step();
        check("b_arready", b_s_arready, 1);
        step(); b_s_arvalid = 1'b0;
    endtask

    task automatic c_ar(input logic [31:0] addr, input logic [2:0] prot);
        c_s_araddr = addr; c_s_arprot = prot; c_s_arvalid = 1'b1;
        for (int n = 0; n < 40 && !c_s_arready; n++) step();
        check("c_arready", c_s_arready, 1);
        step(); c_s_arvalid = 1'b0;
    endtask

    task automatic a_r(input logic [31:0] data, input logic [1:0] resp);
        a_m_rdata = data; a_m_rresp = resp; a_m_rvalid = 1'b1;
        for (int n = 0; n < 40 && !a_m_rready; n++) step();
        check("a_m_rready", a_m_rready, 1);
        step(); a_m_rvalid = 1'b0;
    endtask

    task automatic b_r(input logic [63:0] data, input logic [1:0] resp);
        b_m_rdata = data; b_m_rresp = resp; b_m_rvalid = 1'b1;
        for (int n = 0; n < 40 && !b_m_rready; n++) step();
        check("b_m_rready", b_m_rready, 1);
        step(); b_m_rvalid = 1'b0;
    endtask

    task automatic c_r(input logic [31:0] data, input logic [1:0] resp);
        c_m_rdata = data; c_m_rresp = resp; c_m_rvalid = 1'b1;
        for (int n = 0; n < 40 && !c_m_rready; n++) step();
        check("c_m_rready", c_m_rready, 1);
        step(); c_m_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [63:0] got;
    logic [1:0]  gresp;

    initial begin
        rst = 1'b1;
        {a_s_araddr, a_s_arprot, a_s_arvalid, a_m_rdata, a_m_rresp, a_m_rvalid} = '0;
        {b_s_araddr, b_s_arprot, b_s_arvalid, b_m_rdata, b_m_rresp, b_m_rvalid} = '0;
        {c_s_araddr, c_s_arprot, c_s_arvalid, c_m_rdata, c_m_rresp, c_m_rvalid} = '0;
        a_s_rready = 1'b1; b_s_rready = 1'b1; c_s_rready = 1'b1;
        a_m_arready = 1'b1; b_m_arready = 1'b1; c_m_arready = 1'b1;
        repeat (3) step();

        check("rst_a_arready", a_s_arready, 0);
        check("rst_a_arvalid", a_m_arvalid, 0);
        check("rst_a_rvalid", a_s_rvalid, 0);
        check("rst_a_cnt", a_cnt, 0);
        check("rst_c_m_rready", c_m_rready, 0);
        rst = 1'b0;
        step();

        // Equal mode: four reads in flight, fifth stalls at the limit
        a_ar(32'h0);
        check("a_lat_arvalid", a_m_arvalid, 1);
        check("a_arprot", a_m_arprot, 0);
        a_ar(32'h4); a_ar(32'h8); a_ar(32'hC);
        a_ar(32'h10);
        repeat (3) step();
        check("a_stall_arvalid", a_m_arvalid, 0);
        check("a_stall_cnt", a_cnt, 4);
        check("a_stall_arready", a_s_arready, 0);
        check("a_arq_size", a_arq.size(), 4);
        for (int i = 0; i < 4; i++) check("a_araddr", (a_arq.size() > i) ? a_arq[i] : 32'hFFFF_FFFF, 32'(4 * i));
        for (int i = 0; i < 5; i++) begin
            for (int n = 0; n < 40 && a_arq.size() <= i; n++) step();
            check("a_ar_issued", a_arq.size() > i, 1);
            a_r(32'hD000_0000 | ((a_arq.size() > i) ? a_arq[i] : 32'h0), 2'b00);
        end
        step();
        check("a_rq_size", a_rq.size(), 5);
        for (int i = 0; i < 5; i++) check("a_rdata", (a_rq.size() > i) ? a_rq[i] : '1, 64'(32'hD000_0000 + 32'(4 * i)));
        check("a_rresp", a_s_rresp, 0);
        check("a_cnt_drain", a_cnt, 0);
        a_arq.delete(); a_rq.delete();

        // Expand mode: upper lane selected
        b_ar(32'h4);
        check("b_m_araddr", b_m_araddr, 32'h4);
        b_r(64'h11223344_AABBCCDD, 2'b00);
        step();
        got = '1; gresp = '1;
        if (b_rq.size() != 0) begin got = b_rq.pop_front(); gresp = b_rsq.pop_front(); end
        check("b_rdata", got, 64'h11223344);
        check("b_rresp", gresp, 0);

        // Upstream backpressure with two reads outstanding
        b_s_rready = 1'b0;
        b_ar(32'h0); b_ar(32'h4);
        step();
        check("b_cnt2", b_cnt, 2);
        b_r(64'h55555555_66666666, 2'b00);
        b_m_rdata = 64'h77777777_88888888; b_m_rresp = 2'b00; b_m_rvalid = 1'b1;
        check("b_bp_rready0", b_m_rready, 0);
        step(); step();
        check("b_bp_rready1", b_m_rready, 0);
        check("b_bp_rvalid", b_s_rvalid, 1);
        check("b_bp_rdata", b_s_rdata, 32'h66666666);
        check("b_bp_cnt", b_cnt, 1);
        b_s_rready = 1'b1;
        #1;
        check("b_bp_release", b_m_rready, 1);
        step();
        b_m_rvalid = 1'b0;
        check("b_second_rvalid", b_s_rvalid, 1);
        check("b_second_rdata", b_s_rdata, 32'h77777777);
        step();
        b_rq.delete(); b_rsq.delete();

        // Narrow mode: two sub-reads, second with SLVERR
        c_ar(32'h8, 3'b101);
        check("c_arprot", c_m_arprot, 3'b101);
        c_r(32'hAABBCCDD, 2'b00);
        c_r(32'h11223344, 2'b10);
        step();
        check("c_arq_size", c_arq.size(), 2);
        check("c_araddr0", (c_arq.size() > 0) ? c_arq[0] : '1, 32'h8);
        check("c_araddr1", (c_arq.size() > 1) ? c_arq[1] : '1, 32'hC);
        got = '1; gresp = '0;
        if (c_rq.size() != 0) begin got = c_rq.pop_front(); gresp = c_rsq.pop_front(); end
`ifdef AXIL_ADAPTER_RD_ERR_ZERO_EN
        check("c_rdata_err", got, 64'h00000000_AABBCCDD);
`else
        check("c_rdata_err", got, 64'h11223344_AABBCCDD);
`endif
        check("c_rresp_err", gresp, 2);
        c_arq.delete();

        // Unaligned narrow read, first-beat DECERR retained over later OKAY
        c_ar(32'h14, 3'b000);
        c_r(32'h01234567, 2'b11);
        c_r(32'h89ABCDEF, 2'b00);
        step();
        check("c_araddr_al", (c_arq.size() > 0) ? c_arq[0] : '1, 32'h10);
        got = '1; gresp = '0;
        if (c_rq.size() != 0) begin got = c_rq.pop_front(); gresp = c_rsq.pop_front(); end
`ifdef AXIL_ADAPTER_RD_ERR_ZERO_EN
        check("c_rdata_dec", got, 64'h89ABCDEF_00000000);
`else
        check("c_rdata_dec", got, 64'h89ABCDEF_01234567);
`endif
        check("c_rresp_dec", gresp, 3);
        c_arq.delete();

        // Reset with three outstanding and a partial narrow assembly
        a_ar(32'h0); a_ar(32'h4); a_ar(32'h8);
        step();
        check("pre_rst_a_cnt", a_cnt, 3);
        c_ar(32'h0, 3'b000);
        c_r(32'h01010101, 2'b00);
        rst = 1'b1;
        step();
        check("rst_mid_a_arvalid", a_m_arvalid, 0);
        check("rst_mid_a_cnt", a_cnt, 0);
        check("rst_mid_c_cnt", c_cnt, 0);
        check("rst_mid_c_rvalid", c_s_rvalid, 0);
        check("rst_mid_c_arvalid", c_m_arvalid, 0);
        rst = 1'b0;
        a_arq.delete(); c_arq.delete(); c_rq.delete(); c_rsq.delete();
        a_m_rvalid = 1'b1;
        step();
        check("a_rready_empty", a_m_rready, 0);
        a_m_rvalid = 1'b0;
        check("post_rst_c_rvalid", c_s_rvalid, 0);
        c_ar(32'h0, 3'b000);
        c_r(32'hCAFE0001, 2'b00);
        c_r(32'hCAFE0002, 2'b00);
        step();
        check("post_rst_c_rq", c_rq.size(), 1);
        got = '1; gresp = '1;
        if (c_rq.size() != 0) begin got = c_rq.pop_front(); gresp = c_rsq.pop_front(); end
        check("post_rst_c_rdata", got, 64'hCAFE0002_CAFE0001);
        check("post_rst_c_rresp", gresp, 0);
        check("post_rst_c_cnt", c_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
